// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store memory access controller: request opcodes,
// FSM states, response error codes and small opcode classifiers.
package mem_access_pkg;

  typedef enum logic [2:0] {
    LDST_LB  = 3'b000,
    LDST_LH  = 3'b001,
    LDST_LW  = 3'b010,
    LDST_LBU = 3'b011,
    LDST_LHU = 3'b100,
    LDST_SB  = 3'b101,
    LDST_SH  = 3'b110,
    LDST_SW  = 3'b111
  } ldst_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  function automatic logic is_store(input logic [2:0] op);
    logic r;
    case (ldst_e'(op))
      LDST_SB, LDST_SH, LDST_SW: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_half(input logic [2:0] op);
    logic r;
    case (ldst_e'(op))
      LDST_LH, LDST_LHU, LDST_SH: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    logic r;
    case (ldst_e'(op))
      LDST_LW, LDST_SW: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Pipeline request/response and memory bus signals of the access controller.
// slave is the controller's view; master is the pipeline + memory side.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_ldst;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_ldst, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_ldst, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_byte_lane.sv
// Combinational big-endian lane logic: alignment check, byte enables, store data
// replication and load sign/zero extraction.
module mem_byte_lane
  import mem_access_pkg::*;
(
  input  logic [2:0]  ldst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  ext_ldst,
  input  logic [1:0]  ext_off,
  input  logic [31:0] rdata,
  output logic        misalign,
  output logic [1:0]  eff_off,
  output logic [31:0] word_addr,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [1:0]  off_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign off_s     = addr[1:0];
  assign word_addr = {addr[31:2], 2'b00};

  // Alignment check; eff_off is the offset after force-alignment of halfword/word ops.
  always_comb begin
    misalign = 1'b0;
    eff_off  = off_s;
    if (is_half(ldst)) begin
      misalign = off_s[0];
      eff_off  = {off_s[1], 1'b0};
    end else if (is_word(ldst)) begin
      misalign = (off_s != 2'b00);
      eff_off  = 2'b00;
    end else begin
      misalign = 1'b0;
      eff_off  = off_s;
    end
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = 32'h0000_0000;
    case (ldst_e'(ldst))
      LDST_SB: begin
        be        = 4'b1000 >> eff_off;
        wdata_rep = {4{wdata[7:0]}};
      end
      LDST_SH: begin
        be        = eff_off[1] ? 4'b0011 : 4'b1100;
        wdata_rep = {2{wdata[15:0]}};
      end
      LDST_SW: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = 32'h0000_0000;
      end
    endcase
  end

  // Lane select: offset 0 is the most significant byte.
  always_comb begin
    byte_s = rdata[7:0];
    case (ext_off)
      2'd0:    byte_s = rdata[31:24];
      2'd1:    byte_s = rdata[23:16];
      2'd2:    byte_s = rdata[15:8];
      default: byte_s = rdata[7:0];
    endcase
    if (ext_off[1]) begin
      half_s = rdata[15:0];
    end else begin
      half_s = rdata[31:16];
    end
  end

  // Sign or zero extension of the selected lane.
  always_comb begin
    rdata_ext = 32'h0000_0000;
    case (ldst_e'(ext_ldst))
      LDST_LB:  rdata_ext = {{24{byte_s[7]}}, byte_s};
      LDST_LBU: rdata_ext = {24'h00_0000, byte_s};
      LDST_LH:  rdata_ext = {{16{half_s[15]}}, half_s};
      LDST_LHU: rdata_ext = {16'h0000, half_s};
      LDST_LW:  rdata_ext = rdata;
      default:  rdata_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store memory access controller: IDLE/REQ/WAIT/RESP FSM with bus timeout.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned requests instead of force-aligning.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input logic         clk,
  input logic         rst_n,
  mem_access_if.slave bus
);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_r, state_next_s;
  logic [9:0]  cnt_r;
  logic [2:0]  op_r;
  logic [1:0]  off_r;
  logic        accept_s, trap_s, timeout_s;
  logic [1:0]  err_next_s;
  logic [31:0] rdata_next_s;

  logic        lane_misalign_s;
  logic [1:0]  lane_eff_off_s;
  logic [31:0] lane_word_addr_s, lane_wdata_s, lane_rdata_s;
  logic [3:0]  lane_be_s;

  logic        req_ready_r, busy_r, mem_req_r, mem_we_r, resp_valid_r;
  logic [31:0] mem_addr_r, mem_wdata_r, resp_rdata_r;
  logic [3:0]  mem_be_r;
  logic [1:0]  resp_err_r;

  mem_byte_lane u_lane (
    .ldst      (bus.req_ldst),
    .addr      (bus.req_addr),
    .wdata     (bus.req_wdata),
    .ext_ldst  (op_r),
    .ext_off   (off_r),
    .rdata     (bus.mem_rdata),
    .misalign  (lane_misalign_s),
    .eff_off   (lane_eff_off_s),
    .word_addr (lane_word_addr_s),
    .be        (lane_be_s),
    .wdata_rep (lane_wdata_s),
    .rdata_ext (lane_rdata_s)
  );

  assign trap_s    = lane_misalign_s & TRAP_EN;
  assign timeout_s = (cnt_r >= TO_LAST);

  // Next state plus the response that RESP will present; gnt/rvalid beat the timeout.
  always_comb begin
    state_next_s = state_r;
    err_next_s   = ERR_OK;
    rdata_next_s = 32'h0000_0000;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept_s = 1'b1;
          if (trap_s) begin
            state_next_s = ST_RESP;
            err_next_s   = ERR_MISALIGN;
          end else begin
            state_next_s = ST_REQ;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt) begin
          state_next_s = is_store(op_r) ? ST_RESP : ST_WAIT;
        end else if (timeout_s) begin
          state_next_s = ST_RESP;
          err_next_s   = ERR_TIMEOUT;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          state_next_s = ST_RESP;
          rdata_next_s = lane_rdata_s;
        end else if (timeout_s) begin
          state_next_s = ST_RESP;
          err_next_s   = ERR_TIMEOUT;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latched opcode/offset for load extraction and the shared REQ+WAIT cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= 3'b000;
      off_r <= 2'b00;
      cnt_r <= 10'd0;
    end else if (accept_s) begin
      op_r  <= bus.req_ldst;
      off_r <= lane_eff_off_s;
      cnt_r <= 10'd0;
    end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
      cnt_r <= cnt_r + 10'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered outputs; memory bus fields are loaded at acceptance and held through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_be_r     <= 4'b0000;
      mem_wdata_r  <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 2'b00;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      req_ready_r  <= (state_next_s == ST_IDLE);
      busy_r       <= (state_next_s != ST_IDLE);
      mem_req_r    <= (state_next_s == ST_REQ);
      resp_valid_r <= (state_next_s == ST_RESP);
      resp_err_r   <= err_next_s;
      resp_rdata_r <= rdata_next_s;
      if (state_next_s == ST_REQ) begin
        if (accept_s) begin
          mem_we_r    <= is_store(bus.req_ldst);
          mem_addr_r  <= lane_word_addr_s;
          mem_be_r    <= lane_be_s;
          mem_wdata_r <= lane_wdata_s;
        end else begin
          mem_we_r    <= mem_we_r;
          mem_addr_r  <= mem_addr_r;
          mem_be_r    <= mem_be_r;
          mem_wdata_r <= mem_wdata_r;
        end
      end else begin
        mem_we_r    <= 1'b0;
        mem_addr_r  <= 32'h0000_0000;
        mem_be_r    <= 4'b0000;
        mem_wdata_r <= 32'h0000_0000;
      end
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.busy       = busy_r;
  assign bus.mem_req    = mem_req_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_be     = mem_be_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (default and TIMEOUT_CYCLES=4 instances).
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mem_access_if bus ();
  mem_access_if bus_to ();

  mem_access_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_to)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_ldst  = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic run_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ew);
    bus.mem_gnt = 1'b1;
    drive_req(op, addr, wd);
    chk("st_mem_req", 32'(bus.mem_req), 32'h1);
    chk("st_mem_we", 32'(bus.mem_we), 32'h1);
    chk("st_mem_addr", bus.mem_addr, ea);
    chk("st_mem_be", 32'(bus.mem_be), 32'(ebe));
    chk("st_mem_wdata", bus.mem_wdata, ew);
    chk("st_resp_early", 32'(bus.resp_valid), 32'h0);
    step();
    chk("st_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("st_resp_err", 32'(bus.resp_err), 32'h0);
    chk("st_resp_rdata", bus.resp_rdata, 32'h0);
    chk("st_req_drop", 32'(bus.mem_req), 32'h0);
    bus.mem_gnt = 1'b0;
    step();
    chk("st_idle_valid", 32'(bus.resp_valid), 32'h0);
    chk("st_idle_ready", 32'(bus.req_ready), 32'h1);
  endtask

  task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd,
                          input logic [31:0] ea, input logic [31:0] er);
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    drive_req(op, addr, 32'hFFFF_FFFF);
    chk("ld_mem_req", 32'(bus.mem_req), 32'h1);
    chk("ld_mem_we", 32'(bus.mem_we), 32'h0);
    chk("ld_mem_addr", bus.mem_addr, ea);
    chk("ld_mem_be", 32'(bus.mem_be), 32'hF);
    step();
    chk("ld_wait_valid", 32'(bus.resp_valid), 32'h0);
    chk("ld_wait_busy", 32'(bus.busy), 32'h1);
    bus.mem_gnt = 1'b0;
    step();
    chk("ld_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("ld_resp_rdata", bus.resp_rdata, er);
    chk("ld_resp_err", 32'(bus.resp_err), 32'h0);
    bus.mem_rvalid = 1'b0;
    step();
    chk("ld_idle_rdata", bus.resp_rdata, 32'h0);
    chk("ld_idle_valid", 32'(bus.resp_valid), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.req_ldst = 3'b000; bus.req_wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    bus_to.req_valid = 1'b0; bus_to.req_addr = 32'h0; bus_to.req_ldst = 3'b000;
    bus_to.req_wdata = 32'h0; bus_to.mem_gnt = 1'b0; bus_to.mem_rvalid = 1'b0;
    bus_to.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    rst_n = 1'b1;
    step();

    // Stores: byte/halfword/word lanes.
    run_store(LDST_SB, 32'h0000_0103, 32'h0000_00AB, 32'h0000_0100, 4'b0001, 32'hABAB_ABAB);
    run_store(LDST_SB, 32'h0000_0200, 32'h1234_56C3, 32'h0000_0200, 4'b1000, 32'hC3C3_C3C3);
    run_store(LDST_SH, 32'h0000_0012, 32'h1234_ABCD, 32'h0000_0010, 4'b0011, 32'hABCD_ABCD);
    run_store(LDST_SH, 32'h0000_0010, 32'hFFFF_1357, 32'h0000_0010, 4'b1100, 32'h1357_1357);
    run_store(LDST_SW, 32'h0000_0024, 32'hDEAD_BEEF, 32'h0000_0024, 4'b1111, 32'hDEAD_BEEF);

    // Loads: extension and lane selection.
    run_load(LDST_LH,  32'h0000_0202, 32'h1234_8001, 32'h0000_0200, 32'hFFFF_8001);
    run_load(LDST_LHU, 32'h0000_0202, 32'h1234_8001, 32'h0000_0200, 32'h0000_8001);
    run_load(LDST_LH,  32'h0000_0200, 32'h7FFE_8001, 32'h0000_0200, 32'h0000_7FFE);
    run_load(LDST_LB,  32'h0000_0201, 32'h1234_8001, 32'h0000_0200, 32'h0000_0034);
    run_load(LDST_LB,  32'h0000_0202, 32'h1234_8001, 32'h0000_0200, 32'hFFFF_FF80);
    run_load(LDST_LBU, 32'h0000_0202, 32'h1234_8001, 32'h0000_0200, 32'h0000_0080);
    run_load(LDST_LW,  32'h0000_0204, 32'h1234_8001, 32'h0000_0204, 32'h1234_8001);

    // Misaligned requests.
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    bus.mem_gnt = 1'b1;
    drive_req(LDST_LW, 32'h0000_0301, 32'h0);
    chk("trap_lw_valid", 32'(bus.resp_valid), 32'h1);
    chk("trap_lw_err", 32'(bus.resp_err), 32'h1);
    chk("trap_lw_req", 32'(bus.mem_req), 32'h0);
    chk("trap_lw_rdata", bus.resp_rdata, 32'h0);
    step();
    chk("trap_lw_idle", 32'(bus.resp_valid), 32'h0);
    drive_req(LDST_SH, 32'h0000_0103, 32'hBEEF);
    chk("trap_sh_err", 32'(bus.resp_err), 32'h1);
    chk("trap_sh_req", 32'(bus.mem_req), 32'h0);
    bus.mem_gnt = 1'b0;
    step();
`else
    run_load(LDST_LW, 32'h0000_0301, 32'hCAFE_F00D, 32'h0000_0300, 32'hCAFE_F00D);
    run_store(LDST_SH, 32'h0000_0103, 32'h0000_BEEF, 32'h0000_0100, 4'b0011, 32'hBEEF_BEEF);
    run_load(LDST_LHU, 32'h0000_0201, 32'h1234_8001, 32'h0000_0200, 32'h0000_1234);
`endif

    // Grant delayed by three cycles; request pins change but the bus must not.
    bus.mem_gnt = 1'b0;
    drive_req(LDST_LW, 32'h0000_0040, 32'h0);
    bus.req_addr = 32'hFFFF_FFFF;
    bus.req_ldst = LDST_SB;
    for (int i = 0; i < 4; i++) begin
      chk("dly_mem_req", 32'(bus.mem_req), 32'h1);
      chk("dly_mem_addr", bus.mem_addr, 32'h0000_0040);
      chk("dly_mem_be", 32'(bus.mem_be), 32'hF);
      chk("dly_busy", 32'(bus.busy), 32'h1);
      chk("dly_ready", 32'(bus.req_ready), 32'h0);
      if (i == 3) bus.mem_gnt = 1'b1;
      step();
    end
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    chk("dly_wait_req", 32'(bus.mem_req), 32'h0);
    step();
    chk("dly_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("dly_resp_rdata", bus.resp_rdata, 32'h0BAD_F00D);
    bus.mem_rvalid = 1'b0;
    step();

    // Timeout on the TIMEOUT_CYCLES=4 instance, then a stray rvalid.
    bus_to.req_valid = 1'b1;
    bus_to.req_ldst  = LDST_LW;
    bus_to.req_addr  = 32'h0000_0080;
    step();
    bus_to.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_mem_req", 32'(bus_to.mem_req), 32'h1);
      step();
    end
    chk("to_resp_valid", 32'(bus_to.resp_valid), 32'h1);
    chk("to_resp_err", 32'(bus_to.resp_err), 32'h2);
    chk("to_req_drop", 32'(bus_to.mem_req), 32'h0);
    chk("to_resp_rdata", bus_to.resp_rdata, 32'h0);
    step();
    chk("to_idle_ready", 32'(bus_to.req_ready), 32'h1);
    chk("to_idle_err", 32'(bus_to.resp_err), 32'h0);
    bus_to.mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_stray_rvalid", 32'(bus_to.resp_valid), 32'h0);
    end
    bus_to.mem_rvalid = 1'b0;

    // Reset asserted while in WAIT.
    bus.mem_gnt = 1'b1;
    drive_req(LDST_LW, 32'h0000_0050, 32'h0);
    step();
    bus.mem_gnt = 1'b0;
    chk("rw_busy_before", 32'(bus.busy), 32'h1);
    #2;
    rst_n = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    #1;
    chk("rw_busy", 32'(bus.busy), 32'h0);
    chk("rw_ready", 32'(bus.req_ready), 32'h1);
    chk("rw_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rw_mem_be", 32'(bus.mem_be), 32'h0);
    chk("rw_resp_valid", 32'(bus.resp_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rw_pending_rvalid", 32'(bus.resp_valid), 32'h0);
    step();
    chk("rw_idle_busy", 32'(bus.busy), 32'h0);
    bus.mem_rvalid = 1'b0;
    run_store(LDST_SW, 32'h0000_0060, 32'h1122_3344, 32'h0000_0060, 4'b1111, 32'h1122_3344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
